// File: rtl/ifmap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package   : ifmap_ctrl_pkg
// Brief     : Shared types and helpers for the IFMap window read controller:
//             FSM state encoding, latched layer configuration and the
//             configuration legality check.
// Revision  : 1.0 - initial release
// ============================================================================
package ifmap_ctrl_pkg;

  localparam int FILT_W   = 4;
  localparam int STRIDE_W = 3;
  localparam int ROW_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [FILT_W-1:0]   filt_len;
    logic [STRIDE_W-1:0] stride;
    logic [ROW_W-1:0]    rows;
  } cfg_t;

  // A layer is runnable only if every window fits in the scratchpad and the
  // slide never skips an element (1 <= S <= F <= depth, at least one row).
  function automatic logic cfg_legal(input cfg_t cfg, input int depth);
    int f;
    int s;
    int r;
    f = int'(cfg.filt_len);
    s = int'(cfg.stride);
    r = int'(cfg.rows);
    return (s >= 1) && (s <= f) && (f >= 1) && (f <= depth) && (r >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifmap_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module    : ifmap_ring_ptr
// Brief     : Circular scratchpad pointer. Advances by a variable amount each
//             cycle and wraps modulo DEPTH, which need not be a power of two.
//             A load overrides the advance.
// Revision  : 1.0 - initial release
// ============================================================================
module ifmap_ring_ptr #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic [ADDR_W:0]   inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W:0]   w_wrap;

  // Increment never exceeds DEPTH, so a single conditional subtract wraps it.
  always_comb begin
    w_sum  = {1'b0, ptr_q} + inc_i;
    w_wrap = (w_sum >= DEPTH_C) ? (w_sum - DEPTH_C) : w_sum;
    ptr_d  = load_i ? load_val_i : w_wrap[ADDR_W-1:0];
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/ifmap_window_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module    : ifmap_window_read_ctrl
// Brief     : Sequential IFMap read controller. Owns write pointer, window
//             pointer and occupancy of a circular scratchpad, streams filter
//             windows to the PE, slides by the stride and frees consumed
//             entries so rows longer than the scratchpad are supported.
// Revision  : 1.0 - initial release
// ============================================================================
module ifmap_window_read_ctrl
  import ifmap_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [FILT_W-1:0]   cfg_filt_len_i,
  input  logic [STRIDE_W-1:0] cfg_stride_i,
  input  logic [ROW_W-1:0]    cfg_rows_i,
  input  logic                in_valid_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic                rd_valid_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic                rd_ready_i,
  output logic                win_last_o,
  output logic                row_done_o,
  output logic                layer_done_o,
  output logic                cfg_err_o,
  output logic                busy_o
);

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e            state_q;
  cfg_t              cfg_q;
  logic [FILT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ROW_W-1:0]  row_cnt_q;
  logic              row_closed_q, row_closed_d;
  logic              cfg_err_q;
  logic              row_done_q;
  logic              layer_done_q;

  cfg_t              w_cfg_in;
  logic              w_cfg_ok;
  logic              w_run;
  logic              w_in_ready;
  logic              w_wr_en;
  logic              w_rd_valid;
  logic              w_rd_fire;
  logic              w_off_last;
  logic              w_win_end;
  logic              w_row_end;
  logic              w_last_row;
  logic              w_layer_load;
  logic [CNT_W-1:0]  w_filt;
  logic [CNT_W-1:0]  w_stride;
  logic [CNT_W-1:0]  w_off;
  logic [CNT_W-1:0]  w_wr_inc;
  logic [CNT_W-1:0]  w_win_inc;
  logic [CNT_W-1:0]  w_rd_sum;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_win_ptr;

  assign w_cfg_in = {cfg_filt_len_i, cfg_stride_i, cfg_rows_i};
  assign w_cfg_ok = cfg_legal(w_cfg_in, DEPTH);

  // Handshakes, occupancy update and row-end detection for the current cycle.
  always_comb begin
    w_run      = (state_q == RUN);
    w_filt     = CNT_W'(cfg_q.filt_len);
    w_stride   = CNT_W'(cfg_q.stride);
    w_off      = CNT_W'(off_q);
    w_in_ready = w_run && (count_q < DEPTH_C) && !row_closed_q;
    w_wr_en    = in_valid_i && w_in_ready;
    // A window opens only once all F of its elements are resident, so a row
    // shorter than F never starts a partial window that could not complete.
    w_rd_valid = w_run && (w_off < count_q) && (count_q >= w_filt);
    w_rd_fire  = w_rd_valid && rd_ready_i;
    w_off_last = (off_q == (cfg_q.filt_len - FILT_W'(1)));
    w_win_end  = w_rd_fire && w_off_last;
    count_d    = count_q + CNT_W'(w_wr_en) - (w_win_end ? w_stride : '0);
    off_d      = w_win_end ? '0 : (w_rd_fire ? (off_q + FILT_W'(1)) : off_q);
    row_closed_d = row_closed_q || (w_wr_en && in_last_i);
    w_row_end  = w_run && row_closed_d && (count_d < w_filt) && (off_d == '0);
    w_last_row = (row_cnt_q == (cfg_q.rows - ROW_W'(1)));
    w_layer_load = (state_q == IDLE) && start_i && w_cfg_ok;
    w_wr_inc   = CNT_W'(w_wr_en);
    w_win_inc  = '0;
    if (w_win_end) begin
      w_win_inc = w_stride;
    end else if (state_q == FLUSH) begin
      // Skip the tail of the row that can no longer form a window.
      w_win_inc = count_q;
    end
    w_rd_sum   = CNT_W'(w_win_ptr) + w_off;
  end

  // Control FSM with occupancy, window offset, row counter and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      off_q        <= '0;
      count_q      <= '0;
      row_cnt_q    <= '0;
      row_closed_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      row_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      row_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_q <= w_cfg_in;
            if (w_cfg_ok) begin
              cfg_err_q    <= 1'b0;
              state_q      <= RUN;
              off_q        <= '0;
              count_q      <= '0;
              row_cnt_q    <= '0;
              row_closed_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          count_q      <= count_d;
          off_q        <= off_d;
          row_closed_q <= row_closed_d;
          if (w_row_end) begin
            state_q      <= FLUSH;
            row_done_q   <= 1'b1;
            layer_done_q <= w_last_row;
          end
        end
        FLUSH: begin
          count_q      <= '0;
          off_q        <= '0;
          row_closed_q <= 1'b0;
          if (w_last_row) begin
            row_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
            state_q   <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ifmap_ring_ptr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_layer_load),
    .load_val_i ({ADDR_W{1'b0}}),
    .inc_i      (w_wr_inc),
    .ptr_o      (w_wr_ptr)
  );

  ifmap_ring_ptr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_win_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_layer_load),
    .load_val_i ({ADDR_W{1'b0}}),
    .inc_i      (w_win_inc),
    .ptr_o      (w_win_ptr)
  );

  assign in_ready_o   = w_in_ready;
  assign wr_en_o      = w_wr_en;
  assign wr_addr_o    = w_wr_ptr;
  assign rd_valid_o   = w_rd_valid;
  assign rd_addr_o    = (w_rd_sum >= DEPTH_C) ? ADDR_W'(w_rd_sum - DEPTH_C)
                                              : ADDR_W'(w_rd_sum);
  assign win_last_o   = w_rd_valid && w_off_last;
  assign row_done_o   = row_done_q;
  assign layer_done_o = layer_done_q;
  assign cfg_err_o    = cfg_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire
